// File: rtl/ras_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ras_ckpt                                                     |
// | Description : Return address stack with wrapping overflow and a FIFO of   |
// |               speculative checkpoints ({tos, count, top}) used to rebuild |
// |               the exact stack state of a mispredicted branch.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ras_ckpt #(
   parameter  int VLEN     = 32,
   parameter  int DEPTH    = 8,
   parameter  int NUM_CKPT = 4,
   localparam int CW       = $clog2(NUM_CKPT)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_bp_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [VLEN-1:0] data_i,
   output logic [VLEN:0]   data_o,
   input  logic            ckpt_alloc_i,
   output logic            ckpt_ready_o,
   output logic [CW-1:0]   ckpt_id_o,
   input  logic            ckpt_free_i,
   input  logic            restore_i,
   input  logic [CW-1:0]   restore_id_i
);

   localparam int              c_AW       = $clog2(DEPTH);
   localparam int              c_NW       = $clog2(DEPTH + 1);
   localparam int              c_PW       = CW + 1;
   localparam logic [c_NW-1:0] c_FULL_CNT = c_NW'(DEPTH);

   // stack storage and pointers
   logic [VLEN-1:0] stack_q [DEPTH];
   logic [VLEN-1:0] stack_d [DEPTH];
   logic [c_AW-1:0] tos_q, tos_d;
   logic [c_NW-1:0] count_q, count_d;

   // checkpoint slots and FIFO pointers (MSB of each pointer is the wrap bit)
   logic [c_AW-1:0] ck_tos_q [NUM_CKPT];
   logic [c_AW-1:0] ck_tos_d [NUM_CKPT];
   logic [c_NW-1:0] ck_cnt_q [NUM_CKPT];
   logic [c_NW-1:0] ck_cnt_d [NUM_CKPT];
   logic [VLEN-1:0] ck_top_q [NUM_CKPT];
   logic [VLEN-1:0] ck_top_d [NUM_CKPT];
   logic [c_PW-1:0] head_q, head_d;
   logic [c_PW-1:0] tail_q, tail_d;

   logic [c_PW-1:0] w_occ;
   logic            w_ready;
   logic            w_free_ok;
   logic            w_alloc_ok;
   logic [CW-1:0]   w_rst_off;

   // occupancy never exceeds NUM_CKPT, so its MSB alone marks "full"
   assign w_occ      = tail_q - head_q;
   assign w_ready    = ~w_occ[CW];
   assign w_free_ok  = ckpt_free_i && (w_occ != '0);
   assign w_alloc_ok = ckpt_alloc_i && w_ready && !restore_i && !flush_bp_i;
   // distance of the restored slot from head; selects the correct wrap bit
   assign w_rst_off  = restore_id_i - head_q[CW-1:0];

   assign data_o       = {(count_q != '0), stack_q[tos_q]};
   assign ckpt_ready_o = w_ready;
   assign ckpt_id_o    = tail_q[CW-1:0];

   // next stack state: flush > restore > push/pop
   always_comb begin
      stack_d = stack_q;
      tos_d   = tos_q;
      count_d = count_q;
      if (flush_bp_i) begin
         tos_d   = '0;
         count_d = '0;
      end else if (restore_i) begin
         tos_d   = ck_tos_q[restore_id_i];
         count_d = ck_cnt_q[restore_id_i];
         stack_d[ck_tos_q[restore_id_i]] = ck_top_q[restore_id_i];
      end else if (push_i && pop_i) begin
         stack_d[tos_q] = data_i;
         if (count_q == '0) begin
            count_d = c_NW'(1);
         end
      end else if (push_i) begin
         tos_d = tos_q + c_AW'(1);
         stack_d[tos_q + c_AW'(1)] = data_i;
         if (count_q != c_FULL_CNT) begin
            count_d = count_q + c_NW'(1);
         end
      end else if (pop_i && (count_q != '0)) begin
         tos_d   = tos_q - c_AW'(1);
         count_d = count_q - c_NW'(1);
      end
   end

   // next checkpoint FIFO state; free is applied before restore
   always_comb begin
      ck_tos_d = ck_tos_q;
      ck_cnt_d = ck_cnt_q;
      ck_top_d = ck_top_q;
      head_d   = head_q;
      tail_d   = tail_q;
      if (flush_bp_i) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (w_free_ok) begin
            head_d = head_q + c_PW'(1);
         end
         if (restore_i) begin
            tail_d = head_q + {1'b0, w_rst_off};
            // restoring the slot just freed leaves the FIFO empty
            if (w_free_ok && (w_rst_off == '0)) begin
               tail_d = head_d;
            end
         end else if (w_alloc_ok) begin
            ck_tos_d[tail_q[CW-1:0]] = tos_d;
            ck_cnt_d[tail_q[CW-1:0]] = count_d;
            ck_top_d[tail_q[CW-1:0]] = stack_d[tos_d];
            tail_d = tail_q + c_PW'(1);
         end
      end
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
         for (int i = 0; i < NUM_CKPT; i++) begin
            ck_tos_q[i] <= '0;
            ck_cnt_q[i] <= '0;
            ck_top_q[i] <= '0;
         end
         tos_q   <= '0;
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         stack_q  <= stack_d;
         ck_tos_q <= ck_tos_d;
         ck_cnt_q <= ck_cnt_d;
         ck_top_q <= ck_top_d;
         tos_q    <= tos_d;
         count_q  <= count_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ras_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ras_ckpt                                                  |
// | Description : Scoreboard bench for ras_ckpt with a queue-based reference  |
// |               model of the checkpoint FIFO.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ras_ckpt;

   localparam int VLEN  = 32;
   localparam int DEPTH = 8;
   localparam int NCK   = 4;
   localparam int CW    = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush_bp, push, pop, ck_alloc, ck_free, restore;
   logic [VLEN-1:0] data_in;
   logic [CW-1:0]   restore_id;
   logic [VLEN:0]   data_out;
   logic            ck_ready;
   logic [CW-1:0]   ck_id;

   always #5 clk = ~clk;

   ras_ckpt #(.VLEN(VLEN), .DEPTH(DEPTH), .NUM_CKPT(NCK)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_bp_i   (flush_bp),
      .push_i       (push),
      .pop_i        (pop),
      .data_i       (data_in),
      .data_o       (data_out),
      .ckpt_alloc_i (ck_alloc),
      .ckpt_ready_o (ck_ready),
      .ckpt_id_o    (ck_id),
      .ckpt_free_i  (ck_free),
      .restore_i    (restore),
      .restore_id_i (restore_id)
   );

   typedef struct {
      int              id;
      int              tos;
      int              cnt;
      logic [VLEN-1:0] top;
   } ck_t;

   typedef struct {
      logic [VLEN:0]   d;
      logic            rdy;
      logic [CW-1:0]   id;
   } exp_t;

   // reference model: physical stack array plus a queue of live checkpoints
   logic [VLEN-1:0] mem [DEPTH];
   int              m_tos, m_cnt, m_nid;
   ck_t             ckq[$];
   exp_t            expq[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      m_tos = 0;
      m_cnt = 0;
      m_nid = 0;
      ckq.delete();
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.d   = {(m_cnt != 0), mem[m_tos]};
      e.rdy = (ckq.size() < NCK);
      e.id  = CW'(m_nid);
      return e;
   endfunction

   task automatic model_step(input logic fl, pu, po, input logic [VLEN-1:0] d,
                             input logic al, fr, rs, input logic [CW-1:0] rid);
      bit  ready;
      int  k;
      ck_t c;
      if (fl) begin
         m_tos = 0;
         m_cnt = 0;
         m_nid = 0;
         ckq.delete();
         return;
      end
      ready = (ckq.size() < NCK);
      if (rs) begin
         k = -1;
         foreach (ckq[i]) if (ckq[i].id == int'(rid)) k = i;
         check("restore_id_live", 64'(k >= 0), 64'(1));
         if (k < 0) return;
         c     = ckq[k];
         m_tos = c.tos;
         m_cnt = c.cnt;
         mem[m_tos] = c.top;
         while (ckq.size() > k) void'(ckq.pop_back());
         if (fr && k == 0) m_nid = (int'(rid) + 1) % NCK;
         else begin
            if (fr) void'(ckq.pop_front());
            m_nid = int'(rid);
         end
         return;
      end
      if (pu && po) begin
         mem[m_tos] = d;
         if (m_cnt == 0) m_cnt = 1;
      end else if (pu) begin
         m_tos = (m_tos + 1) % DEPTH;
         mem[m_tos] = d;
         if (m_cnt < DEPTH) m_cnt++;
      end else if (po && m_cnt > 0) begin
         m_tos = (m_tos + DEPTH - 1) % DEPTH;
         m_cnt--;
      end
      if (fr && ckq.size() > 0) void'(ckq.pop_front());
      if (al && ready) begin
         c.id  = m_nid;
         c.tos = m_tos;
         c.cnt = m_cnt;
         c.top = mem[m_tos];
         ckq.push_back(c);
         m_nid = (m_nid + 1) % NCK;
      end
   endtask

   // drive one cycle, then record the expected post-edge outputs
   task automatic step(input logic fl, pu, po, input logic [VLEN-1:0] d,
                       input logic al, fr, rs, input logic [CW-1:0] rid);
      @(negedge clk);
      flush_bp   = fl;
      push       = pu;
      pop        = po;
      data_in    = d;
      ck_alloc   = al;
      ck_free    = fr;
      restore    = rs;
      restore_id = rid;
      @(posedge clk);
      model_step(fl, pu, po, d, al, fr, rs, rid);
      expq.push_back(model_out());
   endtask

   task automatic do_push(input logic [VLEN-1:0] d); step(0, 1, 0, d, 0, 0, 0, 0); endtask
   task automatic do_pop();                          step(0, 0, 1, 0, 0, 0, 0, 0); endtask
   task automatic do_flush();                        step(1, 0, 0, 0, 0, 0, 0, 0); endtask

   // monitor: compares DUT outputs against the scoreboard after every edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            check("data_o", 64'(data_out), 64'(e.d));
            check("ckpt_ready_o", 64'(ck_ready), 64'(e.rdy));
            check("ckpt_id_o", 64'(ck_id), 64'(e.id));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic random_steps(input int n);
      for (int i = 0; i < n; i++) begin
         logic          fl, rs;
         logic [CW-1:0] rid;
         fl  = ($urandom_range(0, 49) == 0);
         rs  = 1'b0;
         rid = CW'($urandom);
         if (ckq.size() > 0 && $urandom_range(0, 14) == 0) begin
            rs  = 1'b1;
            rid = CW'(ckq[$urandom_range(0, ckq.size() - 1)].id);
         end
         step(fl, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), $urandom,
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), rs, rid);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {flush_bp, push, pop, ck_alloc, ck_free, restore} = '0;
      data_in    = '0;
      restore_id = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_data_o", 64'(data_out), 64'(0));
      check("reset_ckpt_ready_o", 64'(ck_ready), 64'(1));
      check("reset_ckpt_id_o", 64'(ck_id), 64'(0));

      // basic LIFO, then underflow
      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      do_pop(); do_pop(); do_pop(); do_pop();

      // overflow wrap: nine pushes into eight entries, then drain
      for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
      for (int i = 0; i < 9; i++) do_pop();

      // checkpoint then restore
      do_flush();
      step(0, 1, 0, 32'hA0, 1, 0, 0, 0);
      do_push(32'hB0); do_pop(); do_pop(); do_push(32'hC0);
      step(0, 0, 0, 0, 0, 0, 1, 0);

      // top-entry repair
      do_flush();
      do_push(32'h30);
      step(0, 1, 0, 32'h40, 1, 0, 0, 0);
      do_pop(); do_push(32'h99);
      step(0, 0, 0, 0, 0, 0, 1, 0);

      // FIFO bounds
      do_flush();
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 2);
      step(0, 0, 0, 0, 0, 1, 1, 1);

      // priority: flush beats everything, restore beats push
      do_push(32'h11);
      step(1, 1, 0, 32'h22, 1, 0, 1, 0);
      step(0, 1, 0, 32'h55, 1, 0, 0, 0);
      do_push(32'h66);
      step(0, 1, 0, 32'h77, 0, 0, 1, 0);

      random_steps(3000);

      // asynchronous reset in the middle of a clock phase
      #3;
      {flush_bp, push, pop, ck_alloc, ck_free, restore} = '0;
      rst_n = 1'b0;
      #1;
      check("async_reset_data_o", 64'(data_out), 64'(0));
      check("async_reset_ckpt_ready_o", 64'(ck_ready), 64'(1));
      check("async_reset_ckpt_id_o", 64'(ck_id), 64'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_pop();
      random_steps(300);

      step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drained", 64'(expq.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
